difftest_csr_arbiter: RTL

- Shares one CSR-state difftest reporting channel among NUM_CORES cores.
- Each core offers a packed CSR snapshot (priv mode plus 17 64-bit CSRs) with a valid/ready handshake.
- The block buffers one snapshot per core and grants the output in round-robin order, tagging each snapshot with its core id.
- Sits between the cores' CSR units and the single CSR-state DPI sink; per-core ordering is preserved and nothing is dropped.

---
 rtl/difftest_csr_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/difftest_csr_arbiter.sv
// Round-robin arbiter sharing one CSR-state difftest channel among NUM_CORES cores.
// Each core owns a one-deep holding slot; granted snapshots land in a single output register.
module difftest_csr_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int SNAP_W    = 1090,
  parameter int ID_W      = 8
) (
  input  logic                        io_clock,
  input  logic                        io_reset_n,
  input  logic [NUM_CORES-1:0]        io_in_valid,
  output logic [NUM_CORES-1:0]        io_in_ready,
  input  logic [NUM_CORES*SNAP_W-1:0] io_in_data,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic [ID_W-1:0]             io_out_coreid,
  output logic [SNAP_W-1:0]           io_out_data,
  output logic                        io_busy
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] held;
  logic [SNAP_W-1:0]    slot_data [NUM_CORES];
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     rr_next;
  logic                 grant_found;
  logic                 out_load;
  logic [NUM_CORES-1:0] release_vec;
  logic [NUM_CORES-1:0] capture;

  assign out_load = !io_out_valid || io_out_ready;

  // Search held slots upward from rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] pos;
    idx         = 0;
    pos         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      pos = PTR_W'(idx);
      if (!grant_found && held[pos]) begin
        grant_found = 1'b1;
        grant_idx   = pos;
      end
    end
  end

  always_comb begin
    int nxt;
    nxt = int'(grant_idx) + 1;
    if (nxt >= NUM_CORES) nxt = 0;
    rr_next = PTR_W'(nxt);
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    assign release_vec[g] = grant_found && out_load && (grant_idx == PTR_W'(g));

    // Slot payload needs no reset: it is only observed once held[g] is set.
    always_ff @(posedge io_clock) begin
      if (capture[g]) slot_data[g] <= io_in_data[g*SNAP_W +: SNAP_W];
    end
  end

  // A slot freed by this cycle's grant can be refilled in the same cycle.
  assign io_in_ready = {NUM_CORES{io_reset_n}} & (~held | release_vec);
  assign capture     = io_in_valid & io_in_ready;

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      held          <= '0;
      io_out_valid  <= 1'b0;
      io_out_coreid <= '0;
      io_out_data   <= '0;
      rr_ptr        <= '0;
    end else begin
      held <= (held & ~release_vec) | capture;
      if (out_load) begin
        io_out_valid <= grant_found;
        if (grant_found) begin
          io_out_data   <= slot_data[grant_idx];
          io_out_coreid <= ID_W'(grant_idx);
          rr_ptr        <= rr_next;
        end
      end
    end
  end

  assign io_busy = (|held) || io_out_valid;

endmodule
